// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the MIPS HI/LO multiply/divide unit.
//   - state_e : 2-bit FSM state encoding (IDLE, MULT, DIV, DONE)
//   - op_e    : operation select (OP_MULT = 0, OP_DIV = 1)
//   - result_t: {hi, lo} result payload
//   - abs_val : two's-complement magnitude; 0x80000000 maps to unsigned 0x80000000
package muldiv_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ITERATIONS = 32;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned WORK_W     = 2 * DATA_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } result_t;

    // Magnitude of a signed word, read back as unsigned.
    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? DATA_W'(-x) : x;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: combinational sign correction for the unsigned restoring divide.
//   quot_i   : raw unsigned quotient |a| / |b|
//   rem_i    : raw unsigned remainder |a| % |b|
//   sign_a_i : sign bit of the dividend
//   sign_b_i : sign bit of the divisor
//   hi_o     : signed remainder (takes the sign of the dividend)
//   lo_o     : signed quotient (negated when operand signs differ), truncated to 32 bits
module muldiv_signfix
    import muldiv_pkg::*;
(
    input  logic [DATA_W-1:0] quot_i,
    input  logic [DATA_W-1:0] rem_i,
    input  logic              sign_a_i,
    input  logic              sign_b_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    // Truncation makes 0x80000000 / -1 wrap back to 0x80000000.
    assign lo_o = (sign_a_i ^ sign_b_i) ? DATA_W'(-quot_i) : quot_i;
    assign hi_o = sign_a_i ? DATA_W'(-rem_i) : rem_i;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative signed MULT (radix-2 Booth) / DIV (restoring) unit feeding HI/LO.
//   clock    : rising-edge clock
//   reset    : asynchronous active-low reset
//   start    : request, sampled only when idle
//   op       : 0 = MULT, 1 = DIV, sampled with start
//   abort    : cancels an in-flight MULT/DIV without completing
//   a_in     : operand A, sampled with start
//   b_in     : operand B, sampled with start
//   busy     : high from the accepting edge until one cycle after the done pulse
//   done     : one-cycle completion pulse
//   div_zero : one-cycle pulse with done when a DIV had b_in = 0 (hi/lo untouched)
//   hi_out   : MULT product[63:32] / DIV remainder
//   lo_out   : MULT product[31:0]  / DIV quotient
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic              abort,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic              div_zero,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // MULT: {acc[64:33], multiplier[32:1], q-1[0]}; DIV: {rem[64:32], quot[31:0]}
    logic [WORK_W-1:0]  work_q, work_d;
    // MULT: multiplicand; DIV: |divisor|
    logic [DATA_W-1:0]  opnd_q, opnd_d;
    op_e                op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dz_q, dz_d;

    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               div_zero_q, div_zero_d;
    result_t            res_q, res_d;

    logic               accept_c;
    logic               b_zero_c;
    logic               last_iter_c;
    op_e                op_in_c;

    logic [DATA_W:0]    acc_ext_c;
    logic [DATA_W:0]    mcand_ext_c;
    logic [DATA_W:0]    booth_sum_c;
    logic [WORK_W-1:0]  booth_work_c;
    logic [DATA_W:0]    div_shift_c;
    logic [DATA_W+1:0]  div_diff_c;
    logic [DATA_W:0]    div_rem_c;
    logic [WORK_W-1:0]  div_work_c;

    logic [DATA_W-1:0]  fix_hi_c;
    logic [DATA_W-1:0]  fix_lo_c;

    // busy_q is still high in the cycle right after DONE, so a start there is dropped.
    assign accept_c    = start && (state_q == ST_IDLE) && !busy_q;
    assign b_zero_c    = (b_in == '0);
    assign last_iter_c = (cnt_q == CNT_W'(ITERATIONS - 1));
    assign op_in_c     = op_e'(op);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    if (op_in_c == OP_MULT) begin
                        state_d = ST_MULT;
                    end else if (b_zero_c) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MULT, ST_DIV: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (last_iter_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One Booth step and one restoring-divide step from the current working register
    always_comb begin
        // 33-bit adder so that subtracting 0x80000000 cannot overflow the accumulator
        acc_ext_c   = {work_q[WORK_W-1], work_q[WORK_W-1:DATA_W+1]};
        mcand_ext_c = {opnd_q[DATA_W-1], opnd_q};
        case (work_q[1:0])
            2'b01:   booth_sum_c = acc_ext_c + mcand_ext_c;
            2'b10:   booth_sum_c = acc_ext_c - mcand_ext_c;
            default: booth_sum_c = acc_ext_c;
        endcase
        booth_work_c = {booth_sum_c, work_q[DATA_W:1]};

        div_shift_c  = {work_q[2*DATA_W-1:DATA_W], work_q[DATA_W-1]};
        div_diff_c   = {1'b0, div_shift_c} - {2'b00, opnd_q};
        div_rem_c    = div_diff_c[DATA_W+1] ? div_shift_c : div_diff_c[DATA_W:0];
        div_work_c   = {div_rem_c, work_q[DATA_W-2:0], ~div_diff_c[DATA_W+1]};
    end

    muldiv_signfix u_signfix (
        .quot_i   (work_q[DATA_W-1:0]),
        .rem_i    (work_q[2*DATA_W-1:DATA_W]),
        .sign_a_i (sign_a_q),
        .sign_b_i (sign_b_q),
        .hi_o     (fix_hi_c),
        .lo_o     (fix_lo_c)
    );

    // Operand capture, iteration counter and working-register update
    always_comb begin
        work_d   = work_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dz_d     = dz_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_d    = '0;
                    op_d     = op_in_c;
                    sign_a_d = a_in[DATA_W-1];
                    sign_b_d = b_in[DATA_W-1];
                    dz_d     = (op_in_c == OP_DIV) && b_zero_c;
                    if (op_in_c == OP_MULT) begin
                        work_d = {{DATA_W{1'b0}}, b_in, 1'b0};
                        opnd_d = a_in;
                    end else begin
                        work_d = {{(DATA_W+1){1'b0}}, abs_val(a_in)};
                        opnd_d = abs_val(b_in);
                    end
                end
            end
            ST_MULT: begin
                if (!abort) begin
                    work_d = booth_work_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            ST_DIV: begin
                if (!abort) begin
                    work_d = div_work_c;
                    cnt_d  = cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Output logic: registered status pulses and HI/LO update on completion
    always_comb begin
        busy_d     = (state_d != ST_IDLE) || (state_q == ST_DONE);
        done_d     = (state_q == ST_DONE);
        div_zero_d = (state_q == ST_DONE) && dz_q;
        res_d      = res_q;
        if ((state_q == ST_DONE) && !dz_q) begin
            if (op_q == OP_DIV) begin
                res_d = {fix_hi_c, fix_lo_c};
            end else begin
                res_d = work_q[WORK_W-1:1];
            end
        end
    end

    // Datapath and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            work_q     <= '0;
            opnd_q     <= '0;
            op_q       <= OP_MULT;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            res_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            dz_q       <= dz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_zero_q <= div_zero_d;
            res_q      <= res_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi_out   = res_q.hi;
    assign lo_out   = res_q.lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed and randomized checks of muldiv_ctrl against a
// plain-arithmetic reference (signed 64-bit multiply, truncating divide).
module tb_muldiv_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic        abort;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [63:0] exp_res;

    muldiv_ctrl dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .abort    (abort),
        .a_in     (a_in),
        .b_in     (b_in),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: {hi, lo} after the operation; divide-by-zero leaves prev untouched.
    function automatic logic [63:0] model(input logic o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] prev);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!o) begin
            p = sa * sb;
            return 64'(p);
        end
        if (b == 32'd0) return prev;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one operation at the current negedge and watch it for a fixed window.
    // pulse_k / abort_k: edge index (E0 = accepting edge) at which a stray start /
    // abort is sampled; -1 disables.
    task automatic run(input string tag, input logic o, input logic [31:0] a,
                       input logic [31:0] b, input int pulse_k, input int abort_k);
        bit          edz;
        bit          aborted;
        int          exp_k;
        int          last_k;
        int          pk;
        int          done_err;
        int          dz_err;
        int          busy_err;
        logic [63:0] new_res;
        edz      = o && (b == 32'd0);
        exp_k    = edz ? 1 : 33;
        aborted  = !edz && (abort_k >= 1) && (abort_k <= 32);
        last_k   = aborted ? abort_k : exp_k + 1;
        pk       = (pulse_k > last_k) ? -1 : pulse_k;
        new_res  = aborted ? exp_res : model(o, a, b, exp_res);
        done_err = 0;
        dz_err   = 0;
        busy_err = 0;
        start = 1'b1;
        op    = o;
        a_in  = a;
        b_in  = b;
        abort = (abort_k == 0);
        @(posedge clock);
        for (int k = 0; k <= exp_k + 40; k++) begin
            @(negedge clock);
            if (done !== (!aborted && (k == exp_k))) done_err++;
            if (div_zero !== (edz && (k == exp_k))) dz_err++;
            if (busy !== (aborted ? (k < abort_k) : (k <= exp_k))) busy_err++;
            start = (k == pk - 1);
            abort = (k == abort_k - 1);
            if (start) begin
                a_in = $urandom;
                b_in = $urandom;
                op   = ~o;
            end
        end
        exp_res = new_res;
        check({tag, "_done_pulse_errs"}, 64'(done_err), 64'd0);
        check({tag, "_divzero_errs"}, 64'(dz_err), 64'd0);
        check({tag, "_busy_errs"}, 64'(busy_err), 64'd0);
        check({tag, "_hi"}, 64'(hi_out), 64'(exp_res[63:32]));
        check({tag, "_lo"}, 64'(lo_out), 64'(exp_res[31:0]));
    endtask

    initial begin
        logic        ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          rpk;
        int          rak;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 1'b0;
        abort   = 1'b0;
        a_in    = '0;
        b_in    = '0;
        exp_res = '0;

        #1 reset = 1'b0;
        #2;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        check("rst_hi", 64'(hi_out), 64'd0);
        check("rst_lo", 64'(lo_out), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Signed multiply, first edge after reset release
        run("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1);
        check("mul_7_m3_hi_lit", 64'(hi_out), 64'hFFFF_FFFF);
        check("mul_7_m3_lo_lit", 64'(lo_out), 64'hFFFF_FFEB);

        run("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
        check("mul_min_min_hi_lit", 64'(hi_out), 64'h4000_0000);
        check("mul_min_min_lo_lit", 64'(lo_out), 64'h0);

        run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        check("div_m7_2_lo_lit", 64'(lo_out), 64'hFFFF_FFFD);
        check("div_m7_2_hi_lit", 64'(hi_out), 64'hFFFF_FFFF);

        run("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        check("div_min_m1_lo_lit", 64'(lo_out), 64'h8000_0000);
        check("div_min_m1_hi_lit", 64'(hi_out), 64'h0);

        // Divide by zero keeps the previous HI/LO
        run("div_zero", 1'b1, 32'h1234_5678, 32'd0, -1, -1);
        check("div_zero_hi_lit", 64'(hi_out), 64'h0);
        check("div_zero_lo_lit", 64'(lo_out), 64'h8000_0000);

        // Stray start mid-operation, aborts, abort outside MULT/DIV
        run("mul_start_pulse", 1'b0, 32'h0001_2345, 32'hFFFF_0F0F, 10, -1);
        run("mul_abort5", 1'b0, 32'h0000_1234, 32'h0000_5678, -1, 5);
        run("div_abort20", 1'b1, 32'h7654_3210, 32'h0000_0013, -1, 20);
        run("abort_in_idle", 1'b0, 32'hDEAD_BEEF, 32'h0000_0101, -1, 0);
        run("abort_in_done", 1'b1, 32'hDEAD_BEEF, 32'h0000_0101, -1, 33);

        // Asynchronous reset in the middle of a DIV
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'h7FFF_FFFF;
        b_in  = 32'd3;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (12) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_div_zero", 64'(div_zero), 64'd0);
        check("midrst_hi", 64'(hi_out), 64'd0);
        check("midrst_lo", 64'(lo_out), 64'd0);
        exp_res = '0;
        @(negedge clock);
        reset = 1'b1;
        run("mul_3_4", 1'b0, 32'd3, 32'd4, -1, -1);
        check("mul_3_4_lo_lit", 64'(lo_out), 64'd12);
        check("mul_3_4_hi_lit", 64'(hi_out), 64'd0);

        // Randomized operations with occasional corner operands, stray starts and aborts
        for (int i = 0; i < 24; i++) begin
            ro = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       ra = 32'h8000_0000;
                2:       rb = 32'hFFFF_FFFF;
                3:       ra = 32'($urandom_range(0, 15));
                default: ;
            endcase
            rpk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : -1;
            rak = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 33)) : -1;
            run($sformatf("rnd%0d", i), ro, ra, rb, rpk, rak);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
